// File: rtl/tinychip_pkg.sv
// Shared definitions for the TinyChip multi-cycle controller: FSM states,
// opcode encodings and the bit layout of the 9-bit instruction word.
package tinychip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BNE = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    // Register-form special operations are keyed on {fn, op}
    localparam logic [3:0] FN_JMP = 4'b1000;
    localparam logic [3:0] FN_CLR = 4'b1101;

    localparam int BT_BIT = 8;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 3;
    localparam int RO_HI  = 2;
    localparam int RO_LO  = 1;
    localparam int FN_BIT = 0;
    localparam int IMM_HI = 2;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/ctrl_regfile.sv
// Architectural register file: two asynchronous operand reads, one debug
// read, one synchronous write port, synchronous active-high reset.
module ctrl_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int RAW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we_i,
    input  logic [RAW-1:0] waddr_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic [RAW-1:0] raddrA_i,
    output logic [DW-1:0]  rdataA_o,
    input  logic [RAW-1:0] raddrB_i,
    output logic [DW-1:0]  rdataB_o,
    input  logic [RAW-1:0] dbgSel_i,
    output logic [DW-1:0]  dbgData_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o  = regs_q[raddrA_i];
    assign rdataB_o  = regs_q[raddrB_i];
    assign dbgData_o = regs_q[dbgSel_i];

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle TinyChip controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// handshaked instruction and data memories and an external ALU.
module multicycle_controller
    import tinychip_pkg::*;
#(
    parameter int DW   = 16,
    parameter int PCW  = 8,
    parameter int AW   = 6,
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_ready,
    input  logic [8:0]     imem_rdata,
    input  logic           imem_last,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [AW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic           dmem_ready,
    input  logic [DW-1:0]  dmem_rdata,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [2:0]     alu_op,
    input  logic [DW-1:0]  alu_out,
    input  logic [1:0]     dbg_sel,
    output logic [DW-1:0]  dbg_data,
    output logic [15:0]    retired,
    output logic           done
);

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [8:0]     instr_q, instr_d;
    logic           last_q, last_d;
    logic [DW-1:0]  opA_q, opA_d;
    logic [DW-1:0]  opB_q, opB_d;
    logic [DW-1:0]  res_q, res_d;
    logic [15:0]    retired_q, retired_d;

    logic          rfWe;
    logic [DW-1:0] rfRdataA, rfRdataB;

    logic       bt, fn;
    logic [2:0] op, imm;
    logic [1:0] rd, ro;
    logic       isJmp, isClr, isBranch, isLw, isSw, isShift, isAlu, branchTaken;
    logic       retire;
    logic [PCW-1:0] pcInc, pcBranch, pcNext;

    assign bt  = instr_q[BT_BIT];
    assign op  = instr_q[OP_HI:OP_LO];
    assign rd  = instr_q[RD_HI:RD_LO];
    assign ro  = instr_q[RO_HI:RO_LO];
    assign fn  = instr_q[FN_BIT];
    assign imm = instr_q[IMM_HI:IMM_LO];

    assign isJmp    = !bt && ({fn, op} == FN_JMP);
    assign isClr    = !bt && ({fn, op} == FN_CLR);
    assign isBranch = bt && ((op == OP_BEQ) || (op == OP_BNE));
    assign isLw     = bt && (op == OP_LW);
    assign isSw     = bt && (op == OP_SW);
    assign isShift  = bt && ((op == OP_SRL) || (op == OP_SLL));
    assign isAlu    = !(isJmp || isClr || isBranch || isLw || isSw || isShift);

    assign branchTaken = (op == OP_BEQ) ? (opA_q == '0) : (opA_q != '0);
    assign pcInc       = pc_q + PCW'(1);
    assign pcBranch    = pc_q + {{(PCW-3){imm[2]}}, imm};

    ctrl_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .RAW  (2)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (rfWe),
        .waddr_i   (rd),
        .wdata_i   (res_q),
        .raddrA_i  (rd),
        .rdataA_o  (rfRdataA),
        .raddrB_i  (ro),
        .rdataB_o  (rfRdataB),
        .dbgSel_i  (dbg_sel),
        .dbgData_o (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            last_q    <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            res_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            last_q    <= last_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            res_q     <= res_d;
            retired_q <= retired_d;
        end
    end

    // Every instruction funnels into a single retire point that bumps the
    // counter, commits the next PC and decides between FETCH and HALT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        last_d     = last_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        res_d      = res_q;
        retired_d  = retired_q;
        rfWe       = 1'b0;
        retire     = 1'b0;
        pcNext     = pcInc;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    last_d  = imem_last;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                opA_d   = rfRdataA;
                opB_d   = rfRdataB;
                state_d = EXEC;
            end
            EXEC: begin
                if (isAlu) begin
                    alu_a   = opA_q;
                    alu_b   = bt ? DW'(imm) : opB_q;
                    alu_op  = op;
                    res_d   = alu_out;
                    state_d = WB;
                end else if (isShift) begin
                    res_d   = (op == OP_SRL) ? (opA_q >> imm) : (opA_q << imm);
                    state_d = WB;
                end else if (isClr) begin
                    res_d   = '0;
                    state_d = WB;
                end else if (isLw || isSw) begin
                    state_d = MEM;
                end else begin
                    retire = 1'b1;
                    if (isJmp) begin
                        pcNext = opB_q[PCW-1:0];
                    end else if (branchTaken) begin
                        pcNext = pcBranch;
                    end
                end
            end
            MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = isSw;
                dmem_addr  = isSw ? opA_q[AW-1:0] : opB_q[AW-1:0];
                dmem_wdata = isSw ? opB_q : '0;
                if (dmem_ready) begin
                    if (isSw) begin
                        retire = 1'b1;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rfWe   = 1'b1;
                retire = 1'b1;
            end
            HALT: begin
                done = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + 16'd1;
            pc_d      = pcNext;
            state_d   = last_q ? HALT : FETCH;
        end
    end

    assign imem_addr = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an ISA-level model predicts fetch addresses, data
// transfers, per-instruction latency and final state for each program.
module tb_multicycle_controller;

    localparam int DW  = 16;
    localparam int PCW = 8;
    localparam int AW  = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_ready;
    logic [8:0]     imem_rdata;
    logic           imem_last;
    logic           dmem_req;
    logic           dmem_we;
    logic [AW-1:0]  dmem_addr;
    logic [DW-1:0]  dmem_wdata;
    logic           dmem_ready;
    logic [DW-1:0]  dmem_rdata;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [2:0]     alu_op;
    logic [DW-1:0]  alu_out;
    logic [1:0]     dbg_sel;
    logic [DW-1:0]  dbg_data;
    logic [15:0]    retired;
    logic           done;

    always #5 clk = ~clk;

    multicycle_controller #(
        .DW   (DW),
        .PCW  (PCW),
        .AW   (AW),
        .NREG (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_last  (imem_last),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .retired    (retired),
        .done       (done)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dmemTxn_t;

    // Stand-in for the external alu_core; opcodes deliberately all differ.
    function automatic logic [DW-1:0] aluRef(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a | b);
            3'd6:    return a + b + 16'd1;
            default: return b ^ 16'h5A5A;
        endcase
    endfunction

    assign alu_out = aluRef(alu_op, alu_a, alu_b);

    logic [8:0]     prog [256];
    logic [DW-1:0]  dmemInit [64];
    logic [DW-1:0]  dmemBus [64];
    logic [PCW-1:0] expFetch [$];
    dmemTxn_t       expDmem [$];
    int             expLat [$];
    logic [DW-1:0]  expRegs [4];
    logic [PCW-1:0] expPc;

    int checks = 0;
    int failures = 0;
    bit waitMode = 0;
    bit stallDmem = 0;
    int fetchCount = 0;
    int lastIdx = 0;

    bit monOn = 0;
    bit havePrev = 0;
    bit prevReq = 0;
    bit prevDone = 0;
    int cyc = 0;
    int startCyc = 0;
    int waitCnt = 0;
    dmemTxn_t monTxn;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic noteFailure(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    // Instruction-set level model: executes k instructions starting at PC 0.
    task automatic runModel(input int k);
        logic [PCW-1:0] pc;
        logic [DW-1:0]  r [4];
        logic [DW-1:0]  md [64];
        logic [8:0]     ins;
        logic [2:0]     op, imm;
        logic [AW-1:0]  a;
        int             rd, ro, off;
        dmemTxn_t       t;
        pc = '0;
        r  = '{default: '0};
        md = dmemInit;
        for (int i = 0; i < k; i++) begin
            ins = prog[pc];
            expFetch.push_back(pc);
            op  = ins[7:5];
            rd  = int'(ins[4:3]);
            ro  = int'(ins[2:1]);
            imm = ins[2:0];
            off = (imm >= 3'd4) ? int'(imm) - 8 : int'(imm);
            if (ins[8]) begin
                case (op)
                    3'd2, 3'd3: begin
                        if ((r[rd] == 0) == (op == 3'd2)) pc = PCW'(int'(pc) + off);
                        else pc = pc + 1'b1;
                        expLat.push_back(3);
                    end
                    3'd4: begin
                        a = r[ro][AW-1:0];
                        t.we = 1'b0; t.addr = a; t.wdata = '0;
                        expDmem.push_back(t);
                        r[rd] = md[a];
                        pc = pc + 1'b1;
                        expLat.push_back(5);
                    end
                    3'd5: begin
                        a = r[rd][AW-1:0];
                        t.we = 1'b1; t.addr = a; t.wdata = r[ro];
                        expDmem.push_back(t);
                        md[a] = r[ro];
                        pc = pc + 1'b1;
                        expLat.push_back(4);
                    end
                    3'd6: begin r[rd] = r[rd] >> imm; pc = pc + 1'b1; expLat.push_back(4); end
                    3'd7: begin r[rd] = r[rd] << imm; pc = pc + 1'b1; expLat.push_back(4); end
                    default: begin
                        r[rd] = aluRef(op, r[rd], DW'(imm));
                        pc = pc + 1'b1;
                        expLat.push_back(4);
                    end
                endcase
            end else if (ins[0] && op == 3'd0) begin
                pc = r[ro][PCW-1:0];
                expLat.push_back(3);
            end else if (ins[0] && op == 3'd5) begin
                r[rd] = '0;
                pc = pc + 1'b1;
                expLat.push_back(4);
            end else begin
                r[rd] = aluRef(op, r[rd], r[ro]);
                pc = pc + 1'b1;
                expLat.push_back(4);
            end
        end
        expRegs = r;
        expPc   = pc;
    endtask

    // Memory responder: random ready/data whenever a request is absent.
    always @(negedge clk) begin
        imem_ready = 1'($urandom);
        imem_rdata = 9'($urandom);
        imem_last  = 1'($urandom);
        dmem_ready = 1'($urandom);
        dmem_rdata = 16'($urandom);
        if (imem_req) begin
            imem_ready = !waitMode || ($urandom_range(0, 2) != 0);
            imem_rdata = prog[imem_addr];
            imem_last  = (fetchCount == lastIdx);
            if (imem_ready) fetchCount++;
        end
        if (dmem_req) begin
            dmem_ready = !stallDmem && (!waitMode || ($urandom_range(0, 2) != 0));
            dmem_rdata = dmemBus[dmem_addr];
            if (dmem_ready && dmem_we) dmemBus[dmem_addr] = dmem_wdata;
        end
    end

    // Monitor: pops expectations on completed handshakes and FETCH/HALT entry.
    always @(negedge clk) begin
        #1;
        if (monOn) begin
            cyc++;
            if ((imem_req && !prevReq) || (done && !prevDone)) begin
                if (havePrev) begin
                    if (expLat.size() == 0) noteFailure("latency queue underflow");
                    else checkOutput("instr latency", 32'(cyc - startCyc), 32'(expLat.pop_front() + waitCnt));
                end
                havePrev = imem_req;
                startCyc = cyc;
                waitCnt  = 0;
            end
            if (imem_req && imem_ready) begin
                if (expFetch.size() == 0) noteFailure("unexpected fetch");
                else checkOutput("fetch addr", 32'(imem_addr), 32'(expFetch.pop_front()));
            end
            if (dmem_req && dmem_ready) begin
                if (expDmem.size() == 0) begin
                    noteFailure("unexpected dmem transfer");
                end else begin
                    monTxn = expDmem.pop_front();
                    checkOutput("dmem we", 32'(dmem_we), 32'(monTxn.we));
                    checkOutput("dmem addr", 32'(dmem_addr), 32'(monTxn.addr));
                    if (monTxn.we) checkOutput("dmem wdata", 32'(dmem_wdata), 32'(monTxn.wdata));
                end
            end
            if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) waitCnt++;
            prevReq  = imem_req;
            prevDone = done;
        end
    end

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fetchCount = 0;
        #1;
    endtask

    task automatic checkRegsZero(input string name);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            checkOutput(name, 32'(dbg_data), 32'h0);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) prog[i] = 9'($urandom);
        for (int i = 0; i < 64; i++) dmemInit[i] = 16'($urandom);
    endtask

    task automatic applyStimulus(input int k, input bit wm);
        int n;
        bit quiet;
        monOn = 0;
        expFetch.delete();
        expDmem.delete();
        expLat.delete();
        dmemBus  = dmemInit;
        waitMode = wm;
        pulseReset();
        lastIdx = k - 1;
        checkOutput("reset imem_req", 32'(imem_req), 32'h0);
        checkOutput("reset dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset pc", 32'(imem_addr), 32'h0);
        checkOutput("reset retired", 32'(retired), 32'h0);
        checkOutput("reset alu", 32'({alu_a, alu_op}), 32'h0);
        checkOutput("reset alu_b", 32'(alu_b), 32'h0);
        checkOutput("reset dmem bus", 32'({dmem_we, dmem_addr, dmem_wdata}), 32'h0);
        checkRegsZero("reset reg");
        runModel(k);
        havePrev = 0; prevReq = 0; prevDone = 0; cyc = 0; waitCnt = 0;
        @(negedge clk);
        start = 1'b1;
        monOn = 1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!done) noteFailure("timeout waiting for done");
        #2;
        checkOutput("retired count", 32'(retired), 32'(k));
        checkOutput("final pc", 32'(imem_addr), 32'(expPc));
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            checkOutput("final reg", 32'(dbg_data), 32'(expRegs[r]));
        end
        quiet = 1;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (imem_req || dmem_req || !done) quiet = 0;
        end
        checkOutput("halt quiet", 32'(quiet), 32'h1);
        checkOutput("fetch queue drained", 32'(expFetch.size()), 32'h0);
        checkOutput("dmem queue drained", 32'(expDmem.size()), 32'h0);
        checkOutput("latency queue drained", 32'(expLat.size()), 32'h0);
        monOn = 0;
    endtask

    task automatic midMemReset();
        int n;
        bit quiet;
        monOn = 0;
        waitMode = 0;
        stallDmem = 1;
        fillRandom();
        prog[0] = 9'b1_000_10_11_1;
        prog[1] = 9'b1_100_01_10_0;
        pulseReset();
        lastIdx = 5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!dmem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        checkOutput("stalled dmem_req", 32'(dmem_req), 32'h1);
        checkOutput("stalled dmem_addr", 32'(dmem_addr), 32'h7);
        checkOutput("stalled dmem_we", 32'(dmem_we), 32'h0);
        dbg_sel = 2'd2;
        #1;
        checkOutput("pre-reset R2", 32'(dbg_data), 32'h7);
        pulseReset();
        checkOutput("post-reset dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("post-reset done", 32'(done), 32'h0);
        checkOutput("post-reset pc", 32'(imem_addr), 32'h0);
        checkOutput("post-reset retired", 32'(retired), 32'h0);
        checkRegsZero("post-reset reg");
        quiet = 1;
        repeat (5) begin
            @(negedge clk);
            #2;
            if (imem_req || dmem_req) quiet = 0;
        end
        checkOutput("idle without start", 32'(quiet), 32'h1);
        stallDmem = 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dbg_sel = 2'd0;
        repeat (2) @(negedge clk);

        // addi R1,5
        fillRandom();
        prog[0] = 9'b1_000_01_10_1;
        applyStimulus(1, 0);

        // R2 = 7 then lw R1,[R2] with 0xBEEF at address 7
        fillRandom();
        prog[0] = 9'b1_000_10_11_1;
        prog[1] = 9'b1_100_01_10_0;
        dmemInit[7] = 16'hBEEF;
        applyStimulus(2, 1);

        // jump to 10, beq taken to 8, beq not taken to 11, bne ends program
        fillRandom();
        prog[0]  = 9'b1_000_11_10_1;
        prog[1]  = 9'b1_000_11_10_1;
        prog[2]  = 9'b0_000_00_11_1;
        prog[10] = 9'b1_010_00_11_0;
        prog[8]  = 9'b1_000_00_00_1;
        prog[9]  = 9'b1_000_10_00_1;
        prog[11] = 9'b1_011_00_11_1;
        applyStimulus(8, 0);

        // bne at PC 0 with offset -1 wraps to 0xFF; branch on last instruction
        fillRandom();
        prog[0]   = 9'b1_011_00_11_1;
        prog[1]   = 9'b1_000_00_00_1;
        prog[2]   = 9'b0_000_00_01_1;
        prog[255] = 9'b1_000_01_01_0;
        applyStimulus(6, 0);

        // R3 = 0x140, jump lands on 0x40, then clear R3
        fillRandom();
        prog[0]  = 9'b1_000_11_10_1;
        prog[1]  = 9'b1_111_11_11_0;
        prog[2]  = 9'b0_000_00_11_1;
        prog[64] = 9'b0_101_11_00_1;
        applyStimulus(4, 0);

        // store, shift, load; last flag on the instruction at PC 3
        fillRandom();
        prog[0] = 9'b1_000_01_01_1;
        prog[1] = 9'b1_101_01_01_0;
        prog[2] = 9'b1_110_01_00_1;
        prog[3] = 9'b1_100_10_01_0;
        applyStimulus(4, 1);

        for (int p = 0; p < 25; p++) begin
            fillRandom();
            applyStimulus(int'($urandom_range(5, 40)), 1'($urandom));
        end

        midMemReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle TinyChip controller.
- Sequences 9-bit instructions through an explicit FSM with a register file, PC, branch/jump logic and retired-instruction counter.
- Talks to instruction and data memories over req/ready handshakes, so memories may insert wait states.
- ALU stays external (alu_core); the block drives its operands and opcode and samples its result.

Parameters:
DW, 16, datapath and register width
PCW, 8, program counter width
AW, 6, data memory address width
NREG, 4, number of architectural registers (rd/ro fields are 2 bits; NREG must be 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin execution from PC 0 (sampled in IDLE)
imem_req  out  1  instruction fetch request
imem_addr  out  PCW  fetch address (current PC)
imem_ready  in  1  fetch completes this cycle
imem_rdata  in  9  instruction, valid when imem_ready
imem_last  in  1  fetched instruction is the last one, valid with imem_ready
dmem_req  out  1  data request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  AW  data address
dmem_wdata  out  DW  store data
dmem_ready  in  1  data transfer completes this cycle
dmem_rdata  in  DW  load data, valid when dmem_ready
alu_a  out  DW  ALU operand 1
alu_b  out  DW  ALU operand 2
alu_op  out  3  ALU opcode
alu_out  in  DW  ALU result (combinational)
dbg_sel  in  2  register debug select
dbg_data  out  DW  R[dbg_sel], combinational
retired  out  16  instructions completed (wraps)
done  out  1  program finished

Behaviour:
- Instruction fields:
  - [8] bt, [7:5] op, [4:3] rd, [2:1] ro, [0] fn.
  - imm = {ro,fn}; zero-extended for ALU use, sign-extended for branch offsets.
- Reset (synchronous, at the clock edge):
  - state = IDLE, PC = 0, all registers = 0, retired = 0.
  - done, imem_req, dmem_req, dmem_we = 0; alu_a, alu_b, alu_op, dmem_addr, dmem_wdata = 0.
  - Reset mid-transfer abandons the outstanding request. Both req outputs are low in the cycle after the reset edge.
- States:
  - IDLE -> FETCH when start = 1.
  - FETCH: hold imem_req = 1 with imem_addr = PC stable until imem_ready = 1. Latch the instruction and the last flag on that cycle -> DECODE.
  - DECODE: 1 cycle; read R[rd] and R[ro] -> EXEC.
  - EXEC: 1 cycle; drive the ALU and latch the result. Then go to MEM (lw/sw), WB (register-writing ops), or retire directly (branch/jump).
  - MEM: hold dmem_req = 1 with stable addr/we/wdata until dmem_ready = 1. lw -> WB; sw retires.
  - WB: write R[rd]; retire.
  - Retire:
    - retired += 1 and update PC.
    - If the latched last flag is set -> HALT, otherwise -> FETCH.
  - HALT: done = 1, no requests; left only by reset.
- Latency with zero-wait memories:
  - ALU, shift and clear ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch and jump: 3 cycles.
  - Each memory wait cycle adds 1.
- Immediate instructions (bt = 1):
  - op 000/001: R[rd] = alu_out with alu_a = R[rd], alu_b = zext(imm), alu_op = op.
  - op 010 beq: if R[rd] == 0, PC = PC + sext(imm); else PC = PC + 1.
  - op 011 bne: taken when R[rd] != 0, same target rule as beq.
  - op 100 lw: R[rd] = mem[R[ro][AW-1:0]].
  - op 101 sw: mem[R[rd][AW-1:0]] = R[ro].
  - op 110: R[rd] = R[rd] >> imm (logical).
  - op 111: R[rd] = R[rd] << imm.
  - lw/sw address using register fields is intentional; imm is ignored for lw/sw.
- Register instructions (bt = 0):
  - {fn,op} = 1000 jump: PC = R[ro][PCW-1:0].
  - {fn,op} = 1101 clear: R[rd] = 0; the ALU is not used.
  - Otherwise: R[rd] = alu_out with alu_a = R[rd], alu_b = R[ro], alu_op = op.
- PC arithmetic is modulo 2^PCW. 2^PCW-1 + 1 wraps to 0; negative offsets wrap.
- A branch or jump on a last instruction still updates PC, then goes to HALT.
- For all non-ALU ops, alu_a, alu_b and alu_op drive 0.
- ready inputs are ignored when the matching req is low.

Decomposition:
- Package tinychip_pkg holds:
  - state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - opcode localparams (OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_SRL, OP_SLL, FN_JMP, FN_CLR);
  - instruction field bit positions.
- One sub-module, ctrl_regfile: NREG x DW, two async read ports plus a debug read port, one sync write port, synchronous reset.

Test Plan:
- PC = 0, R1 = 0, instr 1_000_01_10_1 (imm = 5), bench ALU adds -> R1 = 5, retired = 1, FETCH revisited 4 cycles after first imem_req.
- R2 = 0x0007, lw rd = 1 ro = 2, dmem_ready delayed 3 cycles with rdata 0xBEEF -> dmem_req/addr 7 held 4 cycles, then R1 = 0xBEEF.
- At PC 10 with R0 = 0:
  - beq rd = 0 imm = 110 (-2) -> next imem_addr = 8.
  - Same with R0 = 1 -> 11.
  - bne at PC 0 imm = -1 with R0 = 1 -> 0xFF.
- R3 = 0x0140, jump ro = 3 -> next imem_addr = 0x40. After the next fetch, retired increments once, with no reg or dmem write.
- imem_last = 1 with the instruction at PC 3 -> it executes, done = 1, imem_req stays 0 for 20 further cycles.
- Reset asserted mid-MEM with dmem_ready = 0 -> next cycle dmem_req = 0, done = 0, PC = 0, all registers 0. The block waits in IDLE for start.
